// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the two-port direct-mapped data cache.
package dcache_pkg;

    typedef enum logic [2:0] {IDLE, WB, RD, RDATA, FILL} dc_state_t;

    // Bit positions of the {tag, index, offset} fields inside a word address.
    typedef struct packed {
        int unsigned off_lo;
        int unsigned idx_lo;
        int unsigned tag_lo;
    } dc_split_t;

    function automatic int tag_w(int aw, int iw, int ow);
        return aw - iw - ow;
    endfunction

    function automatic int line_w(int dw, int ow);
        return dw << ow;
    endfunction

    function automatic int mem_aw(int aw);
        return aw + 2;
    endfunction

    function automatic dc_split_t addr_split(int unsigned iw, int unsigned ow);
        dc_split_t s;
        s.off_lo = 0;
        s.idx_lo = ow;
        s.tag_lo = ow + iw;
        return s;
    endfunction

endpackage

// File: rtl/dcache_dp_if.sv
// Line-granular write-back / refill channel between the cache and ddr_master.
interface dcache_dp_if #(
    parameter int ADDR_W   = 25,
    parameter int OFFSET_W = 2,
    parameter int DATA_W   = 32
);
    localparam int LINE_W = dcache_pkg::line_w(DATA_W, OFFSET_W);
    localparam int MEM_AW = dcache_pkg::mem_aw(ADDR_W);

    logic [MEM_AW-1:0] wr_addr;
    logic [LINE_W-1:0] wr_data;
    logic              wr_valid;
    logic              wr_ready;
    logic [MEM_AW-1:0] rd_addr;
    logic              rd_avalid;
    logic              rd_aready;
    logic [LINE_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_dready;

    modport master (
        output wr_addr, wr_data, wr_valid, rd_addr, rd_avalid, rd_dready,
        input  wr_ready, rd_aready, rd_data, rd_valid
    );

    modport slave (
        input  wr_addr, wr_data, wr_valid, rd_addr, rd_avalid, rd_dready,
        output wr_ready, rd_aready, rd_data, rd_valid
    );
endinterface

// File: rtl/dcache_tagram.sv
// Tag array with asynchronous reads; valid/dirty kept in flops so reset clears them.
module dcache_tagram #(
    parameter int INDEX_W = 12,
    parameter int TAG_W   = 11
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] idx_a,
    input  logic [INDEX_W-1:0] idx_b,
    output logic [TAG_W-1:0]   tag_a,
    output logic [TAG_W-1:0]   tag_b,
    output logic               valid_a,
    output logic               valid_b,
    output logic               dirty_a,
    output logic               dirty_b,
    input  logic               fill_en,
    input  logic [INDEX_W-1:0] fill_idx,
    input  logic [TAG_W-1:0]   fill_tag,
    input  logic               set_a,
    input  logic               set_b
);
    localparam int NLINES = 1 << INDEX_W;

    logic [TAG_W-1:0]  tag_mem [NLINES];
    logic [NLINES-1:0] valid_q, valid_d, dirty_q, dirty_d;

    assign tag_a   = tag_mem[idx_a];
    assign tag_b   = tag_mem[idx_b];
    assign valid_a = valid_q[idx_a];
    assign valid_b = valid_q[idx_b];
    assign dirty_a = dirty_q[idx_a];
    assign dirty_b = dirty_q[idx_b];

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (set_a) dirty_d[idx_a] = 1'b1;
        if (set_b) dirty_d[idx_b] = 1'b1;
        if (fill_en) begin
            valid_d[fill_idx] = 1'b1;
            dirty_d[fill_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en) tag_mem[fill_idx] <= fill_tag;
    end
endmodule

// File: rtl/dcache_dp.sv
// Two-port direct-mapped write-back data cache for VLIW memory slots 3 and 4.
module dcache_dp
    import dcache_pkg::*;
#(
    parameter int ADDR_W   = 25,
    parameter int INDEX_W  = 12,
    parameter int OFFSET_W = 2,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid3,
    input  logic              req_valid4,
    input  logic              req_we3,
    input  logic              req_we4,
    input  logic [ADDR_W-1:0] req_addr3,
    input  logic [ADDR_W-1:0] req_addr4,
    input  logic [DATA_W-1:0] req_wdata3,
    input  logic [DATA_W-1:0] req_wdata4,
    output logic [DATA_W-1:0] resp_data3,
    output logic [DATA_W-1:0] resp_data4,
    output logic              cache_stall,
    dcache_dp_if.master       mem
);
    localparam int        TAG_W  = tag_w(ADDR_W, INDEX_W, OFFSET_W);
    localparam int        LINE_W = line_w(DATA_W, OFFSET_W);
    localparam int        MEM_AW = mem_aw(ADDR_W);
    localparam int        NLINES = 1 << INDEX_W;
    localparam dc_split_t SPL    = addr_split(INDEX_W, OFFSET_W);

    logic [TAG_W-1:0]    tag3, tag4, rtag3, rtag4;
    logic [INDEX_W-1:0]  idx3, idx4, m_idx;
    logic [OFFSET_W-1:0] off3, off4;
    logic                rval3, rval4, rdirty3, rdirty4;
    logic                miss3, miss4, commit, st3, st4, ld3, ld4;
    logic                fill_en, victim_ld;

    dc_state_t          state_q, state_d;
    logic [TAG_W-1:0]   vic_tag_q, vic_tag_d, miss_tag_q, miss_tag_d;
    logic [INDEX_W-1:0] idx_q, idx_d;
    logic               ld3_q, ld4_q;
    logic [DATA_W-1:0]  resp3_q, resp3_d, resp4_q, resp4_d, rdw3_q, rdw4_q;
    logic [LINE_W-1:0]  vic_line_q;
    logic [LINE_W-1:0]  dmem [NLINES];

    assign tag3 = req_addr3[SPL.tag_lo +: TAG_W];
    assign tag4 = req_addr4[SPL.tag_lo +: TAG_W];
    assign idx3 = req_addr3[SPL.idx_lo +: INDEX_W];
    assign idx4 = req_addr4[SPL.idx_lo +: INDEX_W];
    assign off3 = req_addr3[SPL.off_lo +: OFFSET_W];
    assign off4 = req_addr4[SPL.off_lo +: OFFSET_W];

    dcache_tagram #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_tagram (
        .clk     (clk),
        .rst_n   (rst_n),
        .idx_a   (idx3),
        .idx_b   (idx4),
        .tag_a   (rtag3),
        .tag_b   (rtag4),
        .valid_a (rval3),
        .valid_b (rval4),
        .dirty_a (rdirty3),
        .dirty_b (rdirty4),
        .fill_en (fill_en),
        .fill_idx(idx_q),
        .fill_tag(miss_tag_q),
        .set_a   (st3),
        .set_b   (st4)
    );

    // A whole bundle commits or nothing does; slot 3's miss is always served first.
    always_comb begin
        miss3       = req_valid3 & ~(rval3 & (rtag3 == tag3));
        miss4       = req_valid4 & ~(rval4 & (rtag4 == tag4));
        cache_stall = (state_q != IDLE) | miss3 | miss4;
        commit      = ~cache_stall;
        st3         = commit & req_valid3 & req_we3;
        st4         = commit & req_valid4 & req_we4;
        ld3         = commit & req_valid3 & ~req_we3;
        ld4         = commit & req_valid4 & ~req_we4;
        m_idx       = miss3 ? idx3 : idx4;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            vic_tag_q  <= '0;
            miss_tag_q <= '0;
            idx_q      <= '0;
            ld3_q      <= 1'b0;
            ld4_q      <= 1'b0;
            resp3_q    <= '0;
            resp4_q    <= '0;
        end else begin
            state_q    <= state_d;
            vic_tag_q  <= vic_tag_d;
            miss_tag_q <= miss_tag_d;
            idx_q      <= idx_d;
            ld3_q      <= ld3;
            ld4_q      <= ld4;
            resp3_q    <= resp3_d;
            resp4_q    <= resp4_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        vic_tag_d  = vic_tag_q;
        miss_tag_d = miss_tag_q;
        idx_d      = idx_q;
        unique case (state_q)
            IDLE: if (miss3 | miss4) begin
                idx_d      = m_idx;
                miss_tag_d = miss3 ? tag3 : tag4;
                vic_tag_d  = miss3 ? rtag3 : rtag4;
                state_d    = (miss3 ? (rval3 & rdirty3) : (rval4 & rdirty4)) ? WB : RD;
            end
            WB:      if (mem.wr_ready)  state_d = RD;
            RD:      if (mem.rd_aready) state_d = RDATA;
            RDATA:   if (mem.rd_valid)  state_d = FILL;
            FILL:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem.wr_valid  = (state_q == WB);
        mem.rd_avalid = (state_q == RD);
        mem.rd_dready = (state_q == RDATA);
        mem.wr_addr   = MEM_AW'({vic_tag_q, idx_q, {(OFFSET_W + 2){1'b0}}});
        mem.rd_addr   = MEM_AW'({miss_tag_q, idx_q, {(OFFSET_W + 2){1'b0}}});
        mem.wr_data   = vic_line_q;
        fill_en       = (state_q == RDATA) & mem.rd_valid;
        victim_ld     = (state_q == IDLE) & (miss3 | miss4);
    end

    // Read-first BRAM: a same-cycle store is not visible to the other slot's load;
    // slot 4's store is ordered last so it wins a same-word collision.
    always_ff @(posedge clk) begin
        rdw3_q <= dmem[idx3][off3 * DATA_W +: DATA_W];
        rdw4_q <= dmem[idx4][off4 * DATA_W +: DATA_W];
        if (victim_ld) vic_line_q <= dmem[m_idx];
        if (fill_en) dmem[idx_q] <= mem.rd_data;
        if (st3) dmem[idx3][off3 * DATA_W +: DATA_W] <= req_wdata3;
        if (st4) dmem[idx4][off4 * DATA_W +: DATA_W] <= req_wdata4;
    end

    // Load data is shown the cycle after commit and then held until the next load.
    always_comb begin
        resp_data3 = ld3_q ? rdw3_q : resp3_q;
        resp_data4 = ld4_q ? rdw4_q : resp4_q;
        resp3_d    = resp_data3;
        resp4_d    = resp_data4;
    end
endmodule

// File: tb/tb_dcache_dp.sv
// Directed bench for dcache_dp: hits, clean/dirty misses, dual miss, collisions, reset.
module tb_dcache_dp;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid3, req_valid4, req_we3, req_we4;
    logic [24:0] req_addr3, req_addr4;
    logic [31:0] req_wdata3, req_wdata4;
    logic [31:0] resp_data3, resp_data4;
    logic        cache_stall;
    int          checks = 0;
    int          errors = 0;
    int          wr_seen = 0;

    dcache_dp_if #(.ADDR_W(25), .OFFSET_W(2), .DATA_W(32)) mif ();

    dcache_dp #(.ADDR_W(25), .INDEX_W(12), .OFFSET_W(2), .DATA_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid3 (req_valid3),
        .req_valid4 (req_valid4),
        .req_we3    (req_we3),
        .req_we4    (req_we4),
        .req_addr3  (req_addr3),
        .req_addr4  (req_addr4),
        .req_wdata3 (req_wdata3),
        .req_wdata4 (req_wdata4),
        .resp_data3 (resp_data3),
        .resp_data4 (resp_data4),
        .cache_stall(cache_stall),
        .mem        (mif)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (mif.wr_valid) wr_seen++;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic v3, input logic w3, input logic [24:0] a3, input logic [31:0] d3,
                       input logic v4, input logic w4, input logic [24:0] a4, input logic [31:0] d4);
        req_valid3 = v3; req_we3 = w3; req_addr3 = a3; req_wdata3 = d3;
        req_valid4 = v4; req_we4 = w4; req_addr4 = a4; req_wdata4 = d4;
        #1;
    endtask

    task automatic idle_req();
        req(1'b0, 1'b0, 25'h0, 32'h0, 1'b0, 1'b0, 25'h0, 32'h0);
    endtask

    // Serve one refill from RD onward; returns after the tick that re-enters IDLE.
    task automatic refill(input string tag, input logic [26:0] exp_addr, input logic [127:0] line,
                          input int adly);
        int n;
        n = 0;
        while (!mif.rd_avalid && n < 20) begin tick(); n++; end
        chk({tag, "_avalid"}, 128'(mif.rd_avalid), 128'(1));
        chk({tag, "_rd_addr"}, 128'(mif.rd_addr), 128'(exp_addr));
        for (int i = 0; i < adly; i++) begin
            tick();
            chk({tag, "_avalid_hold"}, 128'({mif.rd_avalid, mif.rd_addr}), 128'({1'b1, exp_addr}));
        end
        mif.rd_aready = 1'b1;
        tick();
        mif.rd_aready = 1'b0;
        chk({tag, "_dready"}, 128'(mif.rd_dready), 128'(1));
        mif.rd_data  = line;
        mif.rd_valid = 1'b1;
        tick();
        mif.rd_valid = 1'b0;
        chk({tag, "_fill_stall"}, 128'({cache_stall, mif.rd_dready}), 128'(2'b10));
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        mif.wr_ready = 1'b0; mif.rd_aready = 1'b0; mif.rd_valid = 1'b0; mif.rd_data = '0;
        idle_req();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_stall", 128'(cache_stall), 128'(0));
        chk("rst_strobes", 128'({mif.wr_valid, mif.rd_avalid, mif.rd_dready}), 128'(0));
        chk("rst_resp", 128'({resp_data3, resp_data4}), 128'(0));

        // 1: clean miss on 0x40, line {4,3,2,1}
        req(1'b1, 1'b0, 25'h40, 32'h0, 1'b0, 1'b0, 25'h0, 32'h0);
        chk("t1_stall", 128'(cache_stall), 128'(1));
        tick();
        chk("t1_avalid_t1", 128'(mif.rd_avalid), 128'(1));
        refill("t1", 27'h100, 128'h00000004_00000003_00000002_00000001, 0);
        chk("t1_replay_hit", 128'(cache_stall), 128'(0));
        tick();
        idle_req();
        chk("t1_resp", 128'(resp_data3), 128'(1));
        tick();
        chk("t1_resp_hold", 128'(resp_data3), 128'(1));
        chk("t1_no_wb", 128'(wr_seen), 128'(0));

        // 2: store hit then load hit
        req(1'b1, 1'b1, 25'h41, 32'hDEAD, 1'b0, 1'b0, 25'h0, 32'h0);
        chk("t2_st_stall", 128'(cache_stall), 128'(0));
        tick();
        req(1'b1, 1'b0, 25'h41, 32'h0, 1'b0, 1'b0, 25'h0, 32'h0);
        chk("t2_ld_stall", 128'(cache_stall), 128'(0));
        tick();
        idle_req();
        chk("t2_resp", 128'(resp_data3), 128'(32'hDEAD));

        // 3: dirty victim write-back, slow address accept
        req(1'b1, 1'b0, 25'h4041, 32'h0, 1'b0, 1'b0, 25'h0, 32'h0);
        chk("t3_stall", 128'(cache_stall), 128'(1));
        tick();
        chk("t3_wb", 128'({mif.wr_valid, mif.rd_avalid}), 128'(2'b10));
        chk("t3_wr_addr", 128'(mif.wr_addr), 128'(27'h100));
        chk("t3_wr_data", mif.wr_data, 128'h00000004_00000003_0000DEAD_00000001);
        tick();
        chk("t3_wb_hold", 128'({mif.wr_valid, mif.wr_addr}), 128'({1'b1, 27'h100}));
        mif.wr_ready = 1'b1;
        tick();
        mif.wr_ready = 1'b0;
        refill("t3", 27'h10100, 128'h00000013_00000012_00000011_00000010, 5);
        chk("t3_replay_hit", 128'(cache_stall), 128'(0));
        tick();
        idle_req();
        chk("t3_resp", 128'(resp_data3), 128'(32'h11));

        // 4: both slots miss; slot 3 line fetched first, then slot 4
        req(1'b1, 1'b0, 25'h80, 32'h0, 1'b1, 1'b0, 25'h1C5, 32'h0);
        refill("t4a", 27'h200, 128'h00000023_00000022_00000021_00000020, 0);
        chk("t4_still_stall", 128'(cache_stall), 128'(1));
        refill("t4b", 27'h710, 128'h00000033_00000032_00000031_00000030, 1);
        chk("t4_replay_hit", 128'(cache_stall), 128'(0));
        tick();
        idle_req();
        chk("t4_resp", 128'({resp_data3, resp_data4}), 128'({32'h20, 32'h31}));

        // 5: same-word stores (slot 4 wins) and store/load read-first
        req(1'b1, 1'b1, 25'h4042, 32'd7, 1'b1, 1'b1, 25'h4042, 32'd9);
        chk("t5_stall", 128'(cache_stall), 128'(0));
        tick();
        req(1'b1, 1'b1, 25'h4043, 32'd5, 1'b1, 1'b0, 25'h4043, 32'h0);
        tick();
        chk("t5_read_first", 128'(resp_data4), 128'(32'h13));
        req(1'b1, 1'b0, 25'h4042, 32'h0, 1'b1, 1'b0, 25'h4043, 32'h0);
        tick();
        idle_req();
        chk("t5_ld", 128'({resp_data3, resp_data4}), 128'({32'd9, 32'd5}));

        // 6: reset during RDATA abandons the refill and invalidates lines
        req(1'b1, 1'b0, 25'h300, 32'h0, 1'b0, 1'b0, 25'h0, 32'h0);
        tick();
        mif.rd_aready = 1'b1;
        tick();
        mif.rd_aready = 1'b0;
        chk("t6_rdata", 128'(mif.rd_dready), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("t6_rst_strobes", 128'({mif.wr_valid, mif.rd_avalid, mif.rd_dready}), 128'(0));
        chk("t6_rst_resp", 128'(resp_data3), 128'(0));
        idle_req();
        tick();
        rst_n = 1'b1;
        tick();
        req(1'b1, 1'b0, 25'h4041, 32'h0, 1'b0, 1'b0, 25'h0, 32'h0);
        chk("t6_miss_after_rst", 128'(cache_stall), 128'(1));
        tick();
        idle_req();
        chk("t6_refetch", 128'({mif.rd_avalid, mif.rd_addr}), 128'({1'b1, 27'h10100}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
